us_serial_adapter: RTL and testbench
====================================

Name: us_serial_adapter

Overview:
- Downstream consumer of the four Ultrasonic_Sensor channels: snapshots all four distance bytes plus their timeout flags on a host LOAD request.
- Shifts the snapshot out one bit per host NEXT strobe on SOUT, so an external controller can read every sensor over three wires.
- LOAD and NEXT are asynchronous to CLK and are synchronized internally.
- Sits in the top level beside the display path, fed by the same data_us1..4 / t1..t4 nets.

Parameters:
- DATA_W, 8, width of one sensor distance word.
- SYNC_STAGES, 2, flip-flop stages in each LOAD/NEXT synchronizer (min 2).
- HDR_TAG, 4'hA, constant sync nibble sent at the start of every frame.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- LOAD  input  1  async host request; a rising edge starts a new frame.
- NEXT  input  1  async host bit strobe; a rising edge advances one bit.
- US_DATA  input  4*DATA_W  {data_us4,data_us3,data_us2,data_us1}, sensor 1 in LSBs.
- US_TIMEOUT  input  4  {t4,t3,t2,t1}.
- SOUT  output  1  current serial bit, MSB-first.
- BUSY  output  1  high while a frame is loaded and not fully consumed.
- FRAME_DONE  output  1  one-CLK pulse when the last bit is consumed.
- BIT_CNT  output  6  index of the bit currently on SOUT (0 = first).

Behaviour:
- Frame definitions:
  - FRAME_W = 4 + 4 + 4*DATA_W; this is 40 at the default DATA_W.
  - Frame = {HDR_TAG, US_TIMEOUT[3:0], us1, us2, us3, us4}, transmitted MSB-first: HDR_TAG bit3 first, us4 bit0 last.
- Reset (async, RESET=1):
  - SOUT=0, BUSY=0, FRAME_DONE=0, BIT_CNT=0.
  - Shift register cleared, synchronizers cleared, state=IDLE.
  - Reset mid-frame abandons the frame; no FRAME_DONE is issued.
- Synchronization and edge detection:
  - LOAD and NEXT each pass through SYNC_STAGES flops, then a registered previous-value flop.
  - load_rise = sync & ~prev; next_rise is formed the same way.
  - The event registers on CLK edge SYNC_STAGES+1 after the pin is first sampled high, i.e. the 3rd edge at the default.
  - A pulse shorter than one CLK period may be missed; this is not an error.
- State machine (IDLE, SHIFT):
  - IDLE: SOUT=0, BUSY=0, BIT_CNT=0. next_rise is ignored.
  - IDLE, on load_rise: capture the frame into shift_reg, BIT_CNT=0, SOUT=frame MSB, BUSY=1, go to SHIFT. All of this happens on the same CLK edge.
  - SHIFT, next_rise with BIT_CNT < FRAME_W-1: shift left by 1, BIT_CNT += 1. SOUT shows the new MSB from the same edge.
  - SHIFT, next_rise with BIT_CNT == FRAME_W-1: go to IDLE, SOUT=0, BUSY=0, BIT_CNT=0, FRAME_DONE=1 for exactly one cycle.
  - SHIFT, on load_rise: restart. Re-capture a fresh snapshot, BIT_CNT=0, no FRAME_DONE.
- Simultaneous events:
  - load_rise and next_rise on the same cycle: LOAD wins and NEXT is discarded.
  - load_rise on the same cycle as the final next_rise: LOAD wins, the frame restarts, and FRAME_DONE is not pulsed.
- Snapshot rules:
  - US_DATA and US_TIMEOUT are sampled only on the capture edge.
  - Later input changes do not affect the frame in flight.
- Outputs are registered: SOUT, BUSY, FRAME_DONE and BIT_CNT all come from flops, with no combinational path from inputs.
- BIT_CNT never exceeds FRAME_W-1 and has no wrap-around; the frame terminates instead.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> SOUT=0, BUSY=0, BIT_CNT=0, FRAME_DONE=0 immediately, without waiting for a CLK edge.
- Full frame:
  - Stimulus: US_DATA={8'h44,8'h33,8'h22,8'h11}, US_TIMEOUT=4'b0101; pulse LOAD; then 40 NEXT pulses, each high for 4 CLK and low for 4 CLK.
  - Response: serial stream equals 40'hA5_11_22_33_44 MSB-first, with the first SOUT=1 visible 3 CLK after LOAD.
  - Response: BIT_CNT steps 0..39, and FRAME_DONE pulses once for one cycle after the 40th NEXT, with BUSY falling on the same edge.
- Snapshot hold: after LOAD, change US_DATA to all 8'hFF -> the remaining bits still match 8'h11/22/33/44.
- Restart: LOAD again after 10 NEXT pulses -> BIT_CNT returns to 0, SOUT=1 (tag MSB), no FRAME_DONE; 40 more NEXT pulses complete the new frame normally.
- Collision and idle rules:
  - LOAD and NEXT rising together (identical timing) -> BIT_CNT=0, first bit not skipped.
  - NEXT pulses in IDLE -> SOUT stays 0 and BIT_CNT stays 0.
- Glitch / narrow pulse: a NEXT high for less than 1 CLK -> either ignored or counted once, never counted twice; a NEXT held high for 100 CLK -> counted once.

Source files
------------

// File: rtl/us_serial_adapter_if.sv
// Host-side bundle of the ultrasonic serial adapter: the asynchronous LOAD/NEXT
// strobes, the four sensor words with their timeout flags, and the registered
// serial outputs.
interface us_serial_adapter_if #(
    parameter int unsigned DATA_W = 8
);
    logic                  LOAD;
    logic                  NEXT;
    logic [4*DATA_W-1:0]   US_DATA;
    logic [3:0]            US_TIMEOUT;
    logic                  SOUT;
    logic                  BUSY;
    logic                  FRAME_DONE;
    logic [5:0]            BIT_CNT;

    // Host / sensor side: drives strobes and sensor data, observes the stream.
    modport master (
        output LOAD, NEXT, US_DATA, US_TIMEOUT,
        input  SOUT, BUSY, FRAME_DONE, BIT_CNT
    );

    // Adapter side.
    modport slave (
        input  LOAD, NEXT, US_DATA, US_TIMEOUT,
        output SOUT, BUSY, FRAME_DONE, BIT_CNT
    );
endinterface

// File: rtl/us_serial_adapter.sv
// Ultrasonic serial adapter: snapshots the four sensor distance words and their
// timeout flags on a host LOAD edge, then shifts the frame
// {HDR_TAG, timeouts, us1, us2, us3, us4} out MSB-first, one bit per NEXT edge.
// LOAD and NEXT are asynchronous to CLK and are synchronized here.
module us_serial_adapter #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  HDR_TAG     = 4'hA
) (
    input logic                  CLK,
    input logic                  RESET,
    us_serial_adapter_if.slave   bus
);

    localparam int unsigned FRAME_W  = 8 + 4 * DATA_W;
    localparam logic [5:0]  LAST_IDX = 6'(FRAME_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Synchronizer chains, previous-value flops and derived single-cycle events.
    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] next_sync;
    logic                   load_prev;
    logic                   next_prev;
    logic                   load_rise;
    logic                   next_rise;

    // Datapath and control state with their next values.
    state_t                 state, state_nxt;
    logic [FRAME_W-1:0]     shift_reg, shift_nxt;
    logic [5:0]             bit_cnt, cnt_nxt;
    logic                   busy_r, busy_nxt;
    logic                   done_r, done_nxt;
    logic [FRAME_W-1:0]     frame;

    // Bring LOAD and NEXT into the CLK domain and remember the last synchronized level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            load_sync <= '0;
            next_sync <= '0;
            load_prev <= 1'b0;
            next_prev <= 1'b0;
        end else begin
            load_sync <= {load_sync[SYNC_STAGES-2:0], bus.LOAD};
            next_sync <= {next_sync[SYNC_STAGES-2:0], bus.NEXT};
            load_prev <= load_sync[SYNC_STAGES-1];
            next_prev <= next_sync[SYNC_STAGES-1];
        end
    end

    assign load_rise = load_sync[SYNC_STAGES-1] & ~load_prev;
    assign next_rise = next_sync[SYNC_STAGES-1] & ~next_prev;

    // Sensor 1 sits in the LSBs of US_DATA but is transmitted first after the flags.
    assign frame = {HDR_TAG,
                    bus.US_TIMEOUT,
                    bus.US_DATA[0*DATA_W +: DATA_W],
                    bus.US_DATA[1*DATA_W +: DATA_W],
                    bus.US_DATA[2*DATA_W +: DATA_W],
                    bus.US_DATA[3*DATA_W +: DATA_W]};

    // Next-state and next-output decode; LOAD always takes priority over NEXT.
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;

        if (load_rise) begin
            // Capture (or restart) from either state; a coincident NEXT is dropped.
            state_nxt = SHIFT;
            shift_nxt = frame;
            cnt_nxt   = '0;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // NEXT has nothing to advance while idle.
                end
                SHIFT: begin
                    if (next_rise) begin
                        if (bit_cnt == LAST_IDX) begin
                            // Last bit consumed: terminate instead of wrapping.
                            state_nxt = IDLE;
                            shift_nxt = '0;
                            cnt_nxt   = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            shift_nxt = {shift_reg[FRAME_W-2:0], 1'b0};
                            cnt_nxt   = bit_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State, shift register and output flops; reset abandons any frame without FRAME_DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
        end
    end

    // The shift register is cleared whenever idle, so its MSB doubles as the idle-low SOUT.
    assign bus.SOUT       = shift_reg[FRAME_W-1];
    assign bus.BUSY       = busy_r;
    assign bus.FRAME_DONE = done_r;
    assign bus.BIT_CNT    = bit_cnt;

endmodule

// File: tb/tb_us_serial_adapter.sv
// Self-checking bench for us_serial_adapter: table of sensor snapshots with
// hand-computed frames, a bit queue as scoreboard, and hand-written sequences
// for restart, LOAD/NEXT collisions, narrow/long NEXT pulses and async reset.
module tb_us_serial_adapter;

    localparam int FRAME_W = 40;

    logic clk;
    logic rst;

    us_serial_adapter_if #(.DATA_W(8)) bus ();

    us_serial_adapter #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .HDR_TAG     (4'hA)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tmo;
        logic [39:0] frame;
        logic        scramble;  // overwrite inputs right after capture
    } vec_t;

    vec_t vecs[4];

    int   checks = 0;
    int   errors = 0;
    logic sb[$];
    int   exp_idx = 0;
    int   done_cycles = 0;
    logic busy_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Count cycles FRAME_DONE is high; BUSY must drop on the same edge it rises.
    always @(negedge clk) begin
        if (bus.FRAME_DONE === 1'b1) begin
            done_cycles <= done_cycles + 1;
            check("busy_falls_with_done", {62'd0, busy_d, bus.BUSY}, 64'b10);
        end
        busy_d <= bus.BUSY;
    end

    // Raise LOAD (optionally NEXT on the same instant) and load the scoreboard.
    task automatic do_load(input int v, input logic with_next);
        int   d0;
        logic was_busy;
        d0       = done_cycles;
        was_busy = bus.BUSY;
        bus.US_DATA    = vecs[v].data;
        bus.US_TIMEOUT = vecs[v].tmo;
        bus.LOAD = 1'b1;
        if (with_next) bus.NEXT = 1'b1;
        tick();
        tick();
        if (!was_busy) check("load_busy_before_3rd_edge", 64'(bus.BUSY), 64'd0);
        tick();
        check("load_busy", 64'(bus.BUSY), 64'd1);
        check("load_bit_cnt", 64'(bus.BIT_CNT), 64'd0);
        check("load_sout_msb", 64'(bus.SOUT), 64'(vecs[v].frame[39]));
        if (vecs[v].scramble) begin
            bus.US_DATA    = '1;
            bus.US_TIMEOUT = '1;
        end
        tick();
        bus.LOAD = 1'b0;
        bus.NEXT = 1'b0;
        repeat (4) tick();
        check("load_no_frame_done", 64'(done_cycles), 64'(d0));
        check("load_bit_cnt_held", 64'(bus.BIT_CNT), 64'd0);
        sb.delete();
        for (int i = FRAME_W - 1; i >= 0; i--) sb.push_back(vecs[v].frame[i]);
        exp_idx = 0;
    endtask

    // Check the bit on SOUT against the scoreboard, then advance with a NEXT pulse.
    // mode 0: 4 CLK high / 4 low; 1: sub-cycle pulse straddling one edge; 2: held 100 CLK.
    task automatic consume_bit(input int mode);
        logic eb;
        int   d0;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 64'd1, 64'd0);
            return;
        end
        eb = sb.pop_front();
        check($sformatf("sout_bit%0d", exp_idx), 64'(bus.SOUT), 64'(eb));
        check("bit_cnt", 64'(bus.BIT_CNT), 64'(exp_idx));
        d0 = done_cycles;
        case (mode)
            1: begin
                #6 bus.NEXT = 1'b1;
                #4 bus.NEXT = 1'b0;
                repeat (5) tick();
            end
            2: begin
                bus.NEXT = 1'b1;
                repeat (100) tick();
                bus.NEXT = 1'b0;
                repeat (4) tick();
            end
            default: begin
                bus.NEXT = 1'b1;
                repeat (4) tick();
                bus.NEXT = 1'b0;
                repeat (4) tick();
            end
        endcase
        exp_idx++;
        if (exp_idx == FRAME_W) begin
            check("frame_done_once", 64'(done_cycles), 64'(d0 + 1));
            check("end_busy", 64'(bus.BUSY), 64'd0);
            check("end_bit_cnt", 64'(bus.BIT_CNT), 64'd0);
            check("end_sout", 64'(bus.SOUT), 64'd0);
            exp_idx = 0;
        end else begin
            check("no_early_done", 64'(done_cycles), 64'(d0));
            check("busy_mid_frame", 64'(bus.BUSY), 64'd1);
        end
    endtask

    task automatic consume_rest();
        while (exp_idx != 0 || sb.size() == FRAME_W) consume_bit(0);
    endtask

    // NEXT pulse that falls entirely between two CLK edges is never sampled.
    task automatic gap_glitch();
        #3 bus.NEXT = 1'b1;
        #3 bus.NEXT = 1'b0;
        repeat (4) tick();
        check("gap_glitch_bit_cnt", 64'(bus.BIT_CNT), 64'(exp_idx));
        check("gap_glitch_sout", 64'(bus.SOUT), 64'(sb[0]));
    endtask

    task automatic idle_next();
        bus.NEXT = 1'b1;
        repeat (4) tick();
        bus.NEXT = 1'b0;
        repeat (4) tick();
        check("idle_sout", 64'(bus.SOUT), 64'd0);
        check("idle_bit_cnt", 64'(bus.BIT_CNT), 64'd0);
        check("idle_busy", 64'(bus.BUSY), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        vecs[0] = '{data: 32'h4433_2211, tmo: 4'b0101, frame: 40'hA5_11_22_33_44, scramble: 1'b1};
        vecs[1] = '{data: 32'h0180_FF00, tmo: 4'b1010, frame: 40'hAA_00_FF_80_01, scramble: 1'b0};
        vecs[2] = '{data: 32'hDEAD_BEEF, tmo: 4'b1111, frame: 40'hAF_EF_BE_AD_DE, scramble: 1'b1};
        vecs[3] = '{data: 32'h0000_0000, tmo: 4'b0000, frame: 40'hA0_00_00_00_00, scramble: 1'b0};

        rst = 1'b1;
        bus.LOAD = 1'b0;
        bus.NEXT = 1'b0;
        bus.US_DATA = '0;
        bus.US_TIMEOUT = '0;
        repeat (3) tick();
        check("reset_sout", 64'(bus.SOUT), 64'd0);
        check("reset_busy", 64'(bus.BUSY), 64'd0);
        check("reset_done", 64'(bus.FRAME_DONE), 64'd0);
        check("reset_bit_cnt", 64'(bus.BIT_CNT), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven full frames.
        for (int v = 0; v < 4; v++) begin
            do_load(v, 1'b0);
            for (int b = 0; b < FRAME_W; b++) consume_bit(0);
        end

        // NEXT while idle does nothing.
        repeat (3) idle_next();

        // Restart after 10 bits with a fresh snapshot.
        do_load(0, 1'b0);
        repeat (10) consume_bit(0);
        do_load(2, 1'b0);
        for (int b = 0; b < FRAME_W; b++) consume_bit(0);

        // LOAD and NEXT together from idle: first bit must not be skipped.
        do_load(1, 1'b1);
        for (int b = 0; b < FRAME_W; b++) consume_bit(0);

        // Collision mid-frame, then on the final bit (no FRAME_DONE).
        do_load(0, 1'b0);
        repeat (5) consume_bit(0);
        do_load(3, 1'b1);
        repeat (FRAME_W - 1) consume_bit(0);
        do_load(0, 1'b1);
        for (int b = 0; b < FRAME_W; b++) consume_bit(0);

        // Narrow and long NEXT pulses.
        do_load(1, 1'b0);
        repeat (3) consume_bit(0);
        gap_glitch();
        consume_bit(1);
        consume_bit(2);
        for (int b = 5; b < FRAME_W; b++) consume_bit(0);

        // Asynchronous reset mid-frame and mid-cycle.
        do_load(0, 1'b0);
        repeat (2) consume_bit(0);
        d0 = done_cycles;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_reset_sout", 64'(bus.SOUT), 64'd0);
        check("async_reset_busy", 64'(bus.BUSY), 64'd0);
        check("async_reset_done", 64'(bus.FRAME_DONE), 64'd0);
        check("async_reset_bit_cnt", 64'(bus.BIT_CNT), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("reset_abandons_no_done", 64'(done_cycles), 64'(d0));
        sb.delete();
        exp_idx = 0;
        idle_next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
